// File: rtl/ip_msxbus_pkg.sv
// Shared definitions for the MSX-bus arbiter: FSM state encoding, the open-bus
// default value and a helper for sizing grant indices.
package ip_msxbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STROBE_W = 3'd1,
    ST_STROBE_R = 3'd2,
    ST_WAIT_R   = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;

  // A single port still needs a one-bit index so the vectors stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ip_msxbus_arbiter_if.sv
// Bus bundle between the MSX protocol converter / peripherals and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface ip_msxbus_arbiter_if #(
  parameter int N = 4
);

  logic [15:0]    bus_address;
  logic [7:0]     bus_write_data;
  logic           bus_read;
  logic           bus_write;
  logic           bus_io;
  logic           bus_memory;
  logic           bus_io_cs;
  logic           bus_memory_cs;
  logic           bus_read_ready;
  logic [7:0]     bus_read_data;
  logic [N-1:0]   dev_io_cs;
  logic [N-1:0]   dev_memory_cs;
  logic [N-1:0]   dev_read;
  logic [N-1:0]   dev_write;
  logic [15:0]    dev_address;
  logic [7:0]     dev_write_data;
  logic [N-1:0]   dev_read_ready;
  logic [8*N-1:0] dev_read_data;

  modport slave (
    input  bus_address, bus_write_data, bus_read, bus_write, bus_io, bus_memory,
    input  dev_io_cs, dev_memory_cs, dev_read_ready, dev_read_data,
    output bus_io_cs, bus_memory_cs, bus_read_ready, bus_read_data,
    output dev_read, dev_write, dev_address, dev_write_data
  );

  modport master (
    output bus_address, bus_write_data, bus_read, bus_write, bus_io, bus_memory,
    output dev_io_cs, dev_memory_cs, dev_read_ready, dev_read_data,
    input  bus_io_cs, bus_memory_cs, bus_read_ready, bus_read_data,
    input  dev_read, dev_write, dev_address, dev_write_data
  );

endinterface

// File: rtl/ip_msxbus_prio_enc.sv
// Lowest-index-first priority encoder used to pick which peripheral owns a strobe.
module ip_msxbus_prio_enc
  import ip_msxbus_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scanning downwards lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ip_msxbus_arbiter.sv
// MSX-bus arbiter: merges peripheral chip-selects, grants each strobe to one device
// and sequences reads, with a watchdog returning open-bus data if a device stalls.
module ip_msxbus_arbiter
  import ip_msxbus_pkg::*;
#(
  parameter int         N        = 4,
  parameter int         TIMEOUT  = 64,
  parameter logic [7:0] OPEN_BUS = OPEN_BUS_DEFAULT
) (
  input  logic               clk,
  input  logic               n_reset,
  ip_msxbus_arbiter_if.slave bus,
  output logic               busy,
  output logic               timeout_flag
);

  localparam int IW = idx_width(N);
  localparam int CW = $clog2(TIMEOUT);

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  logic [N-1:0]  cand;
  logic [IW-1:0] cand_idx;
  logic          cand_valid;
  logic          sel_ready;
  logic [7:0]    sel_data;
  logic [N-1:0]  dev_read;
  logic [N-1:0]  dev_write;
  logic          read_ready;

  assign cand = (bus.dev_io_cs & {N{bus.bus_io}}) | (bus.dev_memory_cs & {N{bus.bus_memory}});

  ip_msxbus_prio_enc #(.N(N)) u_prio (
    .req   (cand),
    .idx   (cand_idx),
    .valid (cand_valid)
  );

  assign sel_ready = bus.dev_read_ready[grant_q];
  assign sel_data  = bus.dev_read_data[{grant_q, 3'b000} +: 8];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        // A simultaneous read is dropped in favour of the write.
        if ((bus.bus_write || bus.bus_read) && cand_valid) begin
          grant_d = cand_idx;
          addr_d  = bus.bus_address;
          wdata_d = bus.bus_write_data;
          state_d = bus.bus_write ? ST_STROBE_W : ST_STROBE_R;
        end
      end
      ST_STROBE_W: state_d = ST_IDLE;
      ST_STROBE_R: begin
        cnt_d = CW'(TIMEOUT - 1);
        if (sel_ready) begin
          rdata_d = sel_data;
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        if (sel_ready) begin
          rdata_d = sel_data;
          state_d = ST_DONE;
        end else if (cnt_q == '0) begin
          rdata_d   = OPEN_BUS;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dev_read   = '0;
    dev_write  = '0;
    read_ready = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_STROBE_W: dev_write[grant_q] = 1'b1;
      ST_STROBE_R: dev_read[grant_q]  = 1'b1;
      ST_DONE:     read_ready         = 1'b1;
      default:     ;
    endcase
  end

  assign bus.bus_io_cs      = |bus.dev_io_cs;
  assign bus.bus_memory_cs  = |bus.dev_memory_cs;
  assign bus.bus_read_ready = read_ready;
  assign bus.bus_read_data  = rdata_q;
  assign bus.dev_read       = dev_read;
  assign bus.dev_write      = dev_write;
  assign bus.dev_address    = addr_q;
  assign bus.dev_write_data = wdata_q;
  assign timeout_flag       = timeout_q;

endmodule

// File: tb/tb_ip_msxbus_arbiter.sv
// Randomized self-checking bench for ip_msxbus_arbiter against a transaction-level
// model: grant = lowest claiming device, read latency = min(ready delay, TIMEOUT)+1.
module tb_ip_msxbus_arbiter;

  localparam int         N        = 4;
  localparam int         TIMEOUT  = 64;
  localparam logic [7:0] OPEN_BUS = 8'hFF;
  localparam int         NEVER    = 1000;

  logic clk = 1'b0;
  logic n_reset;
  logic busy;
  logic timeout_flag;

  int total = 0;
  int bad   = 0;

  logic [15:0] model_addr;
  logic [7:0]  model_wdata;
  logic [7:0]  model_rdata;
  logic        model_timeout;
  logic [7:0]  dev_data [N];

  ip_msxbus_arbiter_if #(.N(N)) bus_if ();

  ip_msxbus_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .OPEN_BUS(OPEN_BUS)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .bus          (bus_if),
    .busy         (busy),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic rd, input logic wr, input logic [N-1:0] iocs,
                               input logic [N-1:0] memcs, input logic io, input logic mem,
                               input logic [15:0] addr, input logic [7:0] wdata);
    bus_if.bus_read       = rd;
    bus_if.bus_write      = wr;
    bus_if.dev_io_cs      = iocs;
    bus_if.dev_memory_cs  = memcs;
    bus_if.bus_io         = io;
    bus_if.bus_memory     = mem;
    bus_if.bus_address    = addr;
    bus_if.bus_write_data = wdata;
    bus_if.dev_read_ready = '0;
    for (int i = 0; i < N; i++) bus_if.dev_read_data[8*i +: 8] = dev_data[i];
  endtask

  // One complete bus transaction; delay = cycles from dev_read until the granted
  // device raises ready (0 = same cycle), drop_wr fires a stray write mid-read.
  task automatic txn(input logic rd, input logic wr, input logic [N-1:0] iocs,
                     input logic [N-1:0] memcs, input logic io, input logic mem,
                     input logic [15:0] addr, input logic [7:0] wdata,
                     input int delay, input bit drop_wr);
    logic [N-1:0] cand;
    logic [N-1:0] onehot;
    logic [7:0]   exp_data;
    int           g;
    int           lat;
    bit           claimed;
    cand    = (iocs & {N{io}}) | (memcs & {N{mem}});
    g       = lowest_set(cand);
    claimed = (rd || wr) && (g >= 0);
    onehot  = claimed ? (N'(1) << g) : '0;
    applyStimulus(rd, wr, iocs, memcs, io, mem, addr, wdata);
    if (claimed) begin
      model_addr  = addr;
      model_wdata = wdata;
    end
    @(negedge clk);
    checkOutput("bus_io_cs", bus_if.bus_io_cs, |iocs);
    checkOutput("bus_memory_cs", bus_if.bus_memory_cs, |memcs);
    bus_if.bus_read  = 1'b0;
    bus_if.bus_write = 1'b0;
    if (!claimed) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput("unclaimed dev_read", bus_if.dev_read, '0);
        checkOutput("unclaimed dev_write", bus_if.dev_write, '0);
        checkOutput("unclaimed ready", bus_if.bus_read_ready, 1'b0);
        checkOutput("unclaimed busy", busy, 1'b0);
        @(negedge clk);
      end
    end else if (wr) begin
      checkOutput("dev_write", bus_if.dev_write, onehot);
      checkOutput("dev_read in write", bus_if.dev_read, '0);
      checkOutput("dev_address", bus_if.dev_address, model_addr);
      checkOutput("dev_write_data", bus_if.dev_write_data, model_wdata);
      checkOutput("busy write", busy, 1'b1);
      @(negedge clk);
      checkOutput("dev_write end", bus_if.dev_write, '0);
      checkOutput("busy after write", busy, 1'b0);
      checkOutput("read data held", bus_if.bus_read_data, model_rdata);
      @(negedge clk);
    end else begin
      lat      = ((delay <= TIMEOUT) ? delay : TIMEOUT) + 1;
      exp_data = (delay <= TIMEOUT) ? dev_data[g] : OPEN_BUS;
      for (int k = 0; k <= lat + 1; k++) begin
        checkOutput("dev_read", bus_if.dev_read, (k == 0) ? onehot : '0);
        checkOutput("dev_write in read", bus_if.dev_write, '0);
        checkOutput("bus_read_ready", bus_if.bus_read_ready, k == lat);
        checkOutput("bus_read_data", bus_if.bus_read_data, (k >= lat) ? exp_data : model_rdata);
        checkOutput("busy read", busy, k <= lat);
        for (int i = 0; i < N; i++) begin
          bus_if.dev_read_ready[i] = (i == g) ? (k == delay) : 1'($urandom_range(0, 1));
        end
        bus_if.bus_write = drop_wr && (k == 2) && (k < lat);
        @(negedge clk);
      end
      bus_if.bus_write      = 1'b0;
      bus_if.dev_read_ready = '0;
      model_rdata           = exp_data;
      if (delay > TIMEOUT) model_timeout = 1'b1;
    end
    checkOutput("timeout_flag", timeout_flag, model_timeout);
    checkOutput("dev_address held", bus_if.dev_address, model_addr);
    bus_if.dev_io_cs     = '0;
    bus_if.dev_memory_cs = '0;
  endtask

  initial begin
    logic rd;
    logic wr;
    int   dly;
    model_addr    = '0;
    model_wdata   = '0;
    model_rdata   = '0;
    model_timeout = 1'b0;
    for (int i = 0; i < N; i++) dev_data[i] = 8'($urandom);
    n_reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 16'h0000, 8'h00);

    #1;
    checkOutput("reset dev_read", bus_if.dev_read, '0);
    checkOutput("reset dev_write", bus_if.dev_write, '0);
    checkOutput("reset bus_read_ready", bus_if.bus_read_ready, 1'b0);
    checkOutput("reset bus_read_data", bus_if.bus_read_data, 8'h00);
    checkOutput("reset dev_address", bus_if.dev_address, 16'h0000);
    checkOutput("reset dev_write_data", bus_if.dev_write_data, 8'h00);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset timeout_flag", timeout_flag, 1'b0);
    checkOutput("reset bus_io_cs comb", bus_if.bus_io_cs, 1'b1);
    checkOutput("reset bus_memory_cs comb", bus_if.bus_memory_cs, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);

    $display("[TB] directed: write to device 2");
    txn(1'b0, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 16'h00A0, 8'h5A, 0, 1'b0);

    $display("[TB] directed: prioritized read, device 1 ready after 5 cycles");
    dev_data[1] = 8'h3C;
    txn(1'b1, 1'b0, 4'b0000, 4'b0110, 1'b0, 1'b1, 16'h8001, 8'h11, 5, 1'b0);

    $display("[TB] directed: read timeout on device 0");
    txn(1'b1, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 16'h0098, 8'h22, NEVER, 1'b0);

    $display("[TB] directed: unclaimed and overlapping strobes");
    txn(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 16'h1111, 8'h33, 0, 1'b0);
    txn(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 16'h2222, 8'h44, 0, 1'b0);
    txn(1'b1, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, 16'h3333, 8'h55, 10, 1'b1);
    txn(1'b1, 1'b1, 4'b0011, 4'b0000, 1'b1, 1'b0, 16'h4444, 8'h66, 0, 1'b0);
    txn(1'b1, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 16'h5555, 8'h77, 0, 1'b0);
    txn(1'b1, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 16'h6666, 8'h88, TIMEOUT, 1'b0);

    $display("[TB] random transactions");
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) dev_data[i] = 8'($urandom);
      rd  = 1'($urandom_range(0, 1));
      wr  = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      dly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 8));
      txn(rd, wr, 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), dly,
          $urandom_range(0, 3) == 0);
    end

    $display("[TB] reset in the middle of a read");
    applyStimulus(1'b1, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 16'h1234, 8'h77);
    @(negedge clk);
    bus_if.bus_read = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("busy before reset", busy, 1'b1);
    #2 n_reset = 1'b0;
    #1;
    checkOutput("async reset busy", busy, 1'b0);
    checkOutput("async reset timeout_flag", timeout_flag, 1'b0);
    checkOutput("async reset ready", bus_if.bus_read_ready, 1'b0);
    checkOutput("async reset dev_address", bus_if.dev_address, 16'h0000);
    checkOutput("async reset read data", bus_if.bus_read_data, 8'h00);
    model_addr    = '0;
    model_wdata   = '0;
    model_rdata   = '0;
    model_timeout = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    for (int k = 0; k < TIMEOUT + 4; k++) begin
      @(negedge clk);
      checkOutput("no ready after reset", bus_if.bus_read_ready, 1'b0);
      checkOutput("no dev_read after reset", bus_if.dev_read, '0);
    end
    txn(1'b0, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 16'hBEEF, 8'hC3, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
